gba_waitstate_ctrl: RTL and testbench
=====================================

# gba_waitstate_ctrl

Cycle-accurate GBA wait-state generator for the CPU bench memory system: successor to the fixed-count pause generator. Classifies every accepted bus access by region, width and sequentiality, computes its wait count from a programmable WAITCNT value snooped off the bus, and drives `pause` for exactly that many cycles. It sits beside the simulated memories, and its `pause` output feeds the core and every RAM/ROM model.

## Interface
- `CNT_W`, default 5: wait counter width. Must be ≥5, because the worst case is 17.
- `WAITCNT_ADDR`, default 32'h0400_0204: word address of the WAITCNT register.
- `RESET_WAITCNT`, default 16'h0000: WAITCNT value after reset.
- `EWRAM_WAIT`, default 2: fixed per-halfword wait for region 0x2.
- `clk  in  1`: clock.
- `rst_n  in  1`: reset, asynchronous, active-low.
- `req  in  1`: the bus presents a valid access this cycle.
- `addr  in  32`: access address, held by the core while `pause` is high.
- `size  in  2`: `MEM_SIZE_BYTE/HALF/WORD`.
- `write  in  1`: write access.
- `wdata  in  32`: write data, valid in the cycle after the address.
- `ws_en  in  1`: 0 forces every wait to 0 (fast-sim mode).
- `pause  out  1`: stall to the core and memories.
- `waitcnt  out  16`: current WAITCNT register.
- `seq  out  1`: the access accepted at the last edge was sequential (debug).

## Operation
- **Acceptance:** an access is accepted at a clock edge where `req && !pause`.
- **Regions** (by `addr[27:24]`):
  - 0x0, 0x3–0x7: 0 waits, 32-bit bus.
  - 0x2: `EWRAM_WAIT` per half, 16-bit bus.
  - 0x8–0x9 WS0, 0xA–0xB WS1, 0xC–0xD WS2: 16-bit bus.
  - 0xE–0xF SRAM: 8-bit bus.
  - Region 0x1 is unmapped: 0 waits.
- **WAITCNT decode:**
  - N field codes {0,1,2,3} map to waits {4,3,2,8}: SRAM [1:0], WS0 N [3:2], WS1 N [6:5], WS2 N [9:8].
  - S bit 0/1 maps to: WS0 [4] 2/1, WS1 [7] 4/1, WS2 [10] 8/1.
- **Sequential (ROM regions only):**
  - `seq` = last_valid && addr == last_addr + bytes(last_size) && addr[16:0] != 0.
  - A 128 KB boundary always forces N.
  - last_addr, last_size and last_valid update at each acceptance.
  - A cycle with `!req && !pause` clears last_valid.
- **Wait count W per accepted access:**
  - 32-bit regions: 0.
  - 16-bit regions, byte/half: first (N or S for ROM; EWRAM_WAIT for 0x2).
  - 16-bit regions, word: first + second + 1, where second is S for ROM and EWRAM_WAIT for 0x2.
  - SRAM: SRAM wait for any size.
  - `ws_en=0`: W=0.
- **WAITCNT snoop:**
  - An accepted write to word `WAITCNT_ADDR` arms a data phase.
  - At the next `!pause` edge, `wdata[7:0]` loads if lane 0 is enabled, and `wdata[15:8]` if lane 1 is enabled.
  - Lanes: word both; half (addr[1]=0) both; byte addr[1:0]=0 → lane 0, =1 → lane 1.
  - Writes to 0x0400_0206/7 are ignored.
- W is computed combinationally from the `waitcnt` value present at the acceptance edge.

## Timing
- **Reset:** async. `pause`=0, counter=0, `waitcnt`=`RESET_WAITCNT`, `seq`=0, last_valid=0, data phase disarmed.
- **Reset mid-stall:** `pause` drops immediately, and no pending WAITCNT write commits.
- **Pause window:** the counter loads W at the acceptance edge. `pause` = (counter != 0) as a pure register decode, so it is high for exactly W cycles after that edge. An access therefore occupies 1+W cycles.
- The counter decrements every cycle while nonzero. No acceptance happens while `pause`=1.
- **Back-to-back accesses:** the next access can be accepted at the edge where the counter reaches 0 (`pause` low that cycle).
- **WAITCNT timing:**
  - A new WAITCNT affects only accesses accepted after the commit edge.
  - An access accepted at the commit edge itself uses the old value.
- `seq` registers at the acceptance edge.

## Structure
- Shared package `gba_mem_pkg`:
  - region enum (`REG_BIOS…REG_SRAM`) and bus-width enum;
  - N/S decode tables as constant functions;
  - the `MEM_SIZE_*` encodings.
- Sub-module `ws_lookup`: combinational mapping of (region, size, seq, waitcnt, ws_en) to W. The top holds the counter, sequential tracker and snoop.

## Test plan
- **Reset defaults, ROM word read:** `waitcnt`=0, read word @0x0800_0000 → N=4, S=2, W=7; `pause` high exactly 7 cycles, then drops.
- **Sequential ROM halfwords:** program WAITCNT=16'h0014 (half write @0x0400_0204, wdata 0x14), then reads @0x0800_0000 then @0x0800_0002 → W=4 (N), then W=1 (S), `seq`=1.
- **Sequential broken:**
  - sequential halfword @0x0801_FFFE then @0x0802_0000 → second access `seq`=0;
  - an idle cycle between 0x0800_0000/0x0800_0002 → second `seq`=0.
- **Fixed-wait regions:** EWRAM word @0x0200_0000 → W=5; IWRAM word @0x0300_0000 → W=0, back-to-back acceptances every cycle.
- **Max wait and fast-sim:** WAITCNT=16'h0300, word @0x0C00_0000 → W=17 with no counter overflow; same with `ws_en`=0 → W=0.
- **Reset mid-stall:** assert `rst_n`=0 during a 7-cycle pause → `pause`=0 immediately, `waitcnt` back to `RESET_WAITCNT`.

Source files
------------

// File: rtl/gba_mem_pkg.sv
// Shared GBA memory-map definitions: access sizes, regions, bus widths and
// the WAITCNT field decode tables used by the wait-state generator.
package gba_mem_pkg;

  localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
  localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
  localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

  typedef enum logic [3:0] {
    REG_BIOS  = 4'd0,
    REG_UNMAP = 4'd1,
    REG_EWRAM = 4'd2,
    REG_IWRAM = 4'd3,
    REG_IO    = 4'd4,
    REG_PAL   = 4'd5,
    REG_VRAM  = 4'd6,
    REG_OAM   = 4'd7,
    REG_WS0   = 4'd8,
    REG_WS1   = 4'd9,
    REG_WS2   = 4'd10,
    REG_SRAM  = 4'd11
  } region_e;

  typedef enum logic [1:0] {
    BUS_32 = 2'd0,
    BUS_16 = 2'd1,
    BUS_8  = 2'd2
  } bus_w_e;

  // Non-sequential field code to wait count; code 3 is the slow 8-wait setting.
  function automatic logic [3:0] n_wait(input logic [1:0] code);
    logic [3:0] w;
    case (code)
      2'd0:    w = 4'd4;
      2'd1:    w = 4'd3;
      2'd2:    w = 4'd2;
      2'd3:    w = 4'd8;
      default: w = 4'd8;
    endcase
    return w;
  endfunction

  function automatic logic [3:0] s_wait(input region_e r, input logic s_bit);
    logic [3:0] w;
    if (s_bit) begin
      w = 4'd1;
    end else begin
      case (r)
        REG_WS0: w = 4'd2;
        REG_WS1: w = 4'd4;
        REG_WS2: w = 4'd8;
        default: w = 4'd0;
      endcase
    end
    return w;
  endfunction

  function automatic region_e addr_region(input logic [3:0] nib);
    region_e r;
    case (nib)
      4'h0:        r = REG_BIOS;
      4'h1:        r = REG_UNMAP;
      4'h2:        r = REG_EWRAM;
      4'h3:        r = REG_IWRAM;
      4'h4:        r = REG_IO;
      4'h5:        r = REG_PAL;
      4'h6:        r = REG_VRAM;
      4'h7:        r = REG_OAM;
      4'h8, 4'h9:  r = REG_WS0;
      4'hA, 4'hB:  r = REG_WS1;
      4'hC, 4'hD:  r = REG_WS2;
      default:     r = REG_SRAM;
    endcase
    return r;
  endfunction

  function automatic bus_w_e region_bus(input region_e r);
    bus_w_e b;
    case (r)
      REG_EWRAM, REG_WS0, REG_WS1, REG_WS2: b = BUS_16;
      REG_SRAM:                             b = BUS_8;
      default:                              b = BUS_32;
    endcase
    return b;
  endfunction

  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    logic [2:0] n;
    case (sz)
      MEM_SIZE_BYTE: n = 3'd1;
      MEM_SIZE_HALF: n = 3'd2;
      default:       n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/ws_lookup.sv
// Combinational wait-count lookup: region, size, sequentiality and the
// current WAITCNT value give the number of stall cycles for one access.
module ws_lookup
  import gba_mem_pkg::*;
#(
  parameter int CNT_W      = 5,
  parameter int EWRAM_WAIT = 2
) (
  input  region_e          region,
  input  logic [1:0]       size,
  input  logic             seq,
  input  logic [15:0]      waitcnt,
  input  logic             ws_en,
  output logic [CNT_W-1:0] wait_cnt
);

  logic [CNT_W-1:0] n_s;
  logic [CNT_W-1:0] s_s;
  logic [CNT_W-1:0] first_s;
  logic [CNT_W-1:0] second_s;
  logic             unused_s;

  assign unused_s = ^waitcnt[15:11];

  // Per-region N and S wait selection from the WAITCNT fields.
  always_comb begin
    n_s = '0;
    s_s = '0;
    case (region)
      REG_WS0: begin
        n_s = CNT_W'(n_wait(waitcnt[3:2]));
        s_s = CNT_W'(s_wait(REG_WS0, waitcnt[4]));
      end
      REG_WS1: begin
        n_s = CNT_W'(n_wait(waitcnt[6:5]));
        s_s = CNT_W'(s_wait(REG_WS1, waitcnt[7]));
      end
      REG_WS2: begin
        n_s = CNT_W'(n_wait(waitcnt[9:8]));
        s_s = CNT_W'(s_wait(REG_WS2, waitcnt[10]));
      end
      REG_SRAM: begin
        n_s = CNT_W'(n_wait(waitcnt[1:0]));
        s_s = '0;
      end
      default: begin
        n_s = '0;
        s_s = '0;
      end
    endcase
  end

  // A word on a 16-bit bus costs two halfword transfers plus one turnaround.
  always_comb begin
    first_s  = '0;
    second_s = '0;
    wait_cnt = '0;
    if (region == REG_EWRAM) begin
      first_s  = CNT_W'(EWRAM_WAIT);
      second_s = CNT_W'(EWRAM_WAIT);
    end else begin
      first_s  = seq ? s_s : n_s;
      second_s = s_s;
    end
    if (!ws_en) begin
      wait_cnt = '0;
    end else begin
      case (region_bus(region))
        BUS_16: begin
          if (size == MEM_SIZE_WORD) begin
            wait_cnt = first_s + second_s + CNT_W'(1'b1);
          end else begin
            wait_cnt = first_s;
          end
        end
        BUS_8:   wait_cnt = n_s;
        default: wait_cnt = '0;
      endcase
    end
  end

endmodule

// File: rtl/gba_waitstate_ctrl.sv
// GBA wait-state generator: accepts bus accesses, tracks sequential ROM
// streams, snoops WAITCNT writes and stalls the bus for the computed wait.
module gba_waitstate_ctrl
  import gba_mem_pkg::*;
#(
  parameter int          CNT_W         = 5,
  parameter logic [31:0] WAITCNT_ADDR  = 32'h0400_0204,
  parameter logic [15:0] RESET_WAITCNT = 16'h0000,
  parameter int          EWRAM_WAIT    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  input  logic        write,
  input  logic [31:0] wdata,
  input  logic        ws_en,
  output logic        pause,
  output logic [15:0] waitcnt,
  output logic        seq
);

  logic [CNT_W-1:0] cnt_r;
  logic [31:0]      last_addr_r;
  logic [1:0]       last_size_r;
  logic             last_valid_r;
  logic             seq_r;
  logic [15:0]      waitcnt_r;
  logic             armed_r;
  logic [1:0]       lanes_r;

  logic             accept_s;
  region_e          region_s;
  logic             is_rom_s;
  logic             seq_s;
  logic [CNT_W-1:0] wait_s;
  logic             wc_hit_s;
  logic [1:0]       lanes_s;
  logic             unused_s;

  assign unused_s = ^wdata[31:16];
  assign accept_s = req && !pause;
  assign region_s = addr_region(addr[27:24]);
  assign is_rom_s = (region_s == REG_WS0) || (region_s == REG_WS1) || (region_s == REG_WS2);
  assign wc_hit_s = write && (addr[31:2] == WAITCNT_ADDR[31:2]);

  // A 128 KB boundary (addr[16:0]==0) always restarts with a non-sequential access.
  always_comb begin
    seq_s = 1'b0;
    if (last_valid_r && is_rom_s && (addr[16:0] != 17'd0) &&
        (addr == last_addr_r + {29'd0, size_bytes(last_size_r)})) begin
      seq_s = 1'b1;
    end else begin
      seq_s = 1'b0;
    end
  end

  // Byte lanes of WAITCNT touched by this write; the upper halfword is not WAITCNT.
  always_comb begin
    lanes_s = 2'b00;
    case (size)
      MEM_SIZE_WORD: lanes_s = 2'b11;
      MEM_SIZE_HALF: lanes_s = addr[1] ? 2'b00 : 2'b11;
      MEM_SIZE_BYTE: begin
        case (addr[1:0])
          2'd0:    lanes_s = 2'b01;
          2'd1:    lanes_s = 2'b10;
          default: lanes_s = 2'b00;
        endcase
      end
      default: lanes_s = 2'b00;
    endcase
  end

  ws_lookup #(
    .CNT_W      (CNT_W),
    .EWRAM_WAIT (EWRAM_WAIT)
  ) u_ws_lookup (
    .region   (region_s),
    .size     (size),
    .seq      (seq_s),
    .waitcnt  (waitcnt_r),
    .ws_en    (ws_en),
    .wait_cnt (wait_s)
  );

  // Stall counter and sequential-stream tracker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r        <= '0;
      last_addr_r  <= 32'd0;
      last_size_r  <= 2'd0;
      last_valid_r <= 1'b0;
      seq_r        <= 1'b0;
    end else if (accept_s) begin
      cnt_r        <= wait_s;
      last_addr_r  <= addr;
      last_size_r  <= size;
      last_valid_r <= 1'b1;
      seq_r        <= seq_s;
    end else begin
      if (cnt_r != '0) begin
        cnt_r <= cnt_r - CNT_W'(1'b1);
      end else begin
        cnt_r <= cnt_r;
      end
      if (!req && !pause) begin
        last_valid_r <= 1'b0;
      end else begin
        last_valid_r <= last_valid_r;
      end
    end
  end

  // WAITCNT snoop: arm on the address phase, commit on the next unstalled edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waitcnt_r <= RESET_WAITCNT;
      armed_r   <= 1'b0;
      lanes_r   <= 2'b00;
    end else begin
      if (armed_r && !pause) begin
        if (lanes_r[0]) begin
          waitcnt_r[7:0] <= wdata[7:0];
        end else begin
          waitcnt_r[7:0] <= waitcnt_r[7:0];
        end
        if (lanes_r[1]) begin
          waitcnt_r[15:8] <= wdata[15:8];
        end else begin
          waitcnt_r[15:8] <= waitcnt_r[15:8];
        end
      end else begin
        waitcnt_r <= waitcnt_r;
      end
      if (accept_s && wc_hit_s && (lanes_s != 2'b00)) begin
        armed_r <= 1'b1;
        lanes_r <= lanes_s;
      end else if (armed_r && !pause) begin
        armed_r <= 1'b0;
        lanes_r <= 2'b00;
      end else begin
        armed_r <= armed_r;
        lanes_r <= lanes_r;
      end
    end
  end

  assign pause   = (cnt_r != '0);
  assign waitcnt = waitcnt_r;
  assign seq     = seq_r;

endmodule

// File: tb/tb_gba_waitstate_ctrl.sv
// Directed bench for gba_waitstate_ctrl: expected wait/seq pairs are queued
// when an access is driven and compared against the measured pause window.
module tb_gba_waitstate_ctrl;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic [31:0] addr;
  logic [1:0]  size;
  logic        write;
  logic [31:0] wdata;
  logic        ws_en;
  logic        pause;
  logic [15:0] waitcnt;
  logic        seq;

  typedef struct packed {
    logic [7:0] w;
    logic       s;
  } exp_t;

  exp_t sb_q[$];
  int   vectors;
  int   miscompares;
  int   cyc;
  int   acc_cyc;

  gba_waitstate_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .addr    (addr),
    .size    (size),
    .write   (write),
    .wdata   (wdata),
    .ws_en   (ws_en),
    .pause   (pause),
    .waitcnt (waitcnt),
    .seq     (seq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one access, measure its pause window, then compare against the scoreboard.
  task automatic access(input string tag, input logic [31:0] a, input logic [1:0] sz,
                        input logic wr, input logic [31:0] wd,
                        input int exp_w, input logic exp_s);
    int   n;
    int   g;
    logic obs_s;
    exp_t e;
    @(negedge clk);
    g = 0;
    while (pause && g < 50) begin
      @(negedge clk);
      g++;
    end
    req   = 1'b1;
    addr  = a;
    size  = sz;
    write = wr;
    e.w = 8'(exp_w);
    e.s = exp_s;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    req   = 1'b0;
    write = 1'b0;
    if (wr) wdata = wd;
    obs_s = seq;
    n = 0;
    while (pause && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_wait"}, 32'(n), 32'(e.w));
      check({tag, "_seq"}, {31'd0, obs_s}, {31'd0, e.s});
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int prev;
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    acc_cyc     = 0;
    rst_n = 1'b0;
    req   = 1'b0;
    addr  = 32'd0;
    size  = SZ_B;
    write = 1'b0;
    wdata = 32'd0;
    ws_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pause", {31'd0, pause}, 32'd0);
    check("rst_waitcnt", {16'd0, waitcnt}, 32'h0000);
    check("rst_seq", {31'd0, seq}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    access("rom_word_n", 32'h0800_0000, SZ_W, 1'b0, 32'd0, 7, 1'b0);
    idle();
    access("wc_wr_14", 32'h0400_0204, SZ_H, 1'b1, 32'h0000_0014, 0, 1'b0);
    access("rom_h0_oldwc", 32'h0800_0000, SZ_H, 1'b0, 32'd0, 4, 1'b0);
    check("wc_0014", {16'd0, waitcnt}, 32'h0014);
    access("rom_h2_seq", 32'h0800_0002, SZ_H, 1'b0, 32'd0, 1, 1'b1);
    access("rom_h4_seq", 32'h0800_0004, SZ_H, 1'b0, 32'd0, 1, 1'b1);
    idle();
    access("rom_1fffe", 32'h0801_FFFE, SZ_H, 1'b0, 32'd0, 3, 1'b0);
    access("rom_128k", 32'h0802_0000, SZ_H, 1'b0, 32'd0, 3, 1'b0);
    access("rom_20002", 32'h0802_0002, SZ_H, 1'b0, 32'd0, 1, 1'b1);
    idle();
    access("rom_gap_a", 32'h0800_0000, SZ_H, 1'b0, 32'd0, 3, 1'b0);
    idle();
    access("rom_gap_b", 32'h0800_0002, SZ_H, 1'b0, 32'd0, 3, 1'b0);

    access("ewram_word", 32'h0200_0000, SZ_W, 1'b0, 32'd0, 5, 1'b0);
    access("ewram_half", 32'h0200_0004, SZ_H, 1'b0, 32'd0, 2, 1'b0);
    access("unmapped", 32'h0100_0000, SZ_W, 1'b0, 32'd0, 0, 1'b0);
    access("iwram_0", 32'h0300_0000, SZ_W, 1'b0, 32'd0, 0, 1'b0);
    for (int i = 1; i < 3; i++) begin
      prev = acc_cyc;
      access("iwram_b2b", 32'h0300_0000 + 32'(i * 4), SZ_W, 1'b0, 32'd0, 0, 1'b0);
      check("iwram_b2b_cyc", 32'(acc_cyc - prev), 32'd1);
    end

    access("wc_lane0", 32'h0400_0204, SZ_B, 1'b1, 32'h0000_FF01, 0, 1'b0);
    idle();
    check("wc_0001", {16'd0, waitcnt}, 32'h0001);
    access("sram_byte", 32'h0E00_0010, SZ_B, 1'b0, 32'd0, 3, 1'b0);
    access("sram_word", 32'h0F00_0000, SZ_W, 1'b0, 32'd0, 3, 1'b0);
    access("wc_lane1", 32'h0400_0205, SZ_B, 1'b1, 32'h0000_07EE, 0, 1'b0);
    idle();
    check("wc_0701", {16'd0, waitcnt}, 32'h0701);
    access("wc_ignored", 32'h0400_0206, SZ_H, 1'b1, 32'hFFFF_FFFF, 0, 1'b0);
    idle();
    check("wc_still_0701", {16'd0, waitcnt}, 32'h0701);
    access("ws2_word_s1", 32'h0C00_0000, SZ_W, 1'b0, 32'd0, 10, 1'b0);
    access("wc_wr_0300", 32'h0400_0204, SZ_W, 1'b1, 32'h0000_0300, 0, 1'b0);
    idle();
    check("wc_0300", {16'd0, waitcnt}, 32'h0300);
    access("ws2_max", 32'h0C00_0000, SZ_W, 1'b0, 32'd0, 17, 1'b0);
    idle();
    ws_en = 1'b0;
    access("ws2_fastsim", 32'h0C00_0000, SZ_W, 1'b0, 32'd0, 0, 1'b0);
    ws_en = 1'b1;
    idle();
    access("ws1_half_n", 32'h0A00_0000, SZ_H, 1'b0, 32'd0, 4, 1'b0);
    access("ws1_half_s", 32'h0A00_0002, SZ_H, 1'b0, 32'd0, 4, 1'b1);
    idle();

    // Reset in the middle of a 7-cycle stall.
    @(negedge clk);
    req   = 1'b1;
    addr  = 32'h0800_0000;
    size  = SZ_W;
    write = 1'b0;
    @(posedge clk);
    #1;
    req = 1'b0;
    check("stall_start", {31'd0, pause}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_pause", {31'd0, pause}, 32'd0);
    check("midrst_waitcnt", {16'd0, waitcnt}, 32'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset between a WAITCNT address phase and its data phase.
    @(negedge clk);
    req   = 1'b1;
    addr  = 32'h0400_0204;
    size  = SZ_H;
    write = 1'b1;
    @(posedge clk);
    #1;
    req   = 1'b0;
    write = 1'b0;
    wdata = 32'h0000_1234;
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("no_commit_after_rst", {16'd0, waitcnt}, 32'h0000);
    check("rst_pause_idle", {31'd0, pause}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
